// File: rtl/restoring_divider_seq.sv
// restoring_divider_seq
//   Sequential unsigned restoring divider. A start request accepted in IDLE
//   captures Dividend/Divisor. The divider then spends W cycles in DIV, doing
//   one shift/subtract/restore step per cycle, and pulses done for one cycle
//   in DONE. A zero divisor skips DIV and goes straight to DONE with
//   Quotient = all ones, Remainder = Dividend and Errorout[0] set.
//
// Ports
//   clk        system clock, rising edge
//   rstn       asynchronous active-low reset
//   start      request, sampled only in IDLE
//   Dividend   W-bit numerator, captured on accepted start
//   Divisor    W-bit denominator, captured on accepted start
//   Quotient   W-bit quotient, held until the next completion
//   Remainder  W-bit remainder, held until the next completion
//   busy       high while in DIV
//   done       one-cycle pulse in DONE
//   Errorout   bit0 = divide-by-zero on last operation, bit1 = 0
//   state      FSM state (IDLE=00, DIV=01, DONE=10), debug
//   counter    remaining iterations, debug
module restoring_divider_seq #(
  parameter int W  = 4,
  parameter int CW = 3
) (
  input  logic          clk,
  input  logic          rstn,
  input  logic          start,
  input  logic [W-1:0]  Dividend,
  input  logic [W-1:0]  Divisor,
  output logic [W-1:0]  Quotient,
  output logic [W-1:0]  Remainder,
  output logic          busy,
  output logic          done,
  output logic [1:0]    Errorout,
  output logic [1:0]    state,
  output logic [CW-1:0] counter
);

  typedef enum logic [1:0] {
    IDLE = 2'b00,
    DIV  = 2'b01,
    DONE = 2'b10
  } state_t;

  state_t        state_q, state_d;
  logic [W-1:0]  a_q, a_d;
  logic [W-1:0]  q_q, q_d;
  logic [W-1:0]  m_q, m_d;
  logic [W-1:0]  quot_q, quot_d;
  logic [W-1:0]  rem_q, rem_d;
  logic [CW-1:0] cnt_q, cnt_d;
  logic          err_q, err_d;

  logic [W:0]    shifted;
  logic [W:0]    diff;

  // State register
  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      state_q <= IDLE;
      a_q     <= '0;
      q_q     <= '0;
      m_q     <= '0;
      quot_q  <= '0;
      rem_q   <= '0;
      cnt_q   <= '0;
      err_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      a_q     <= a_d;
      q_q     <= q_d;
      m_q     <= m_d;
      quot_q  <= quot_d;
      rem_q   <= rem_d;
      cnt_q   <= cnt_d;
      err_q   <= err_d;
    end
  end

  // Next-state and datapath
  always_comb begin
    state_d = state_q;
    a_d     = a_q;
    q_d     = q_q;
    m_d     = m_q;
    quot_d  = quot_q;
    rem_d   = rem_q;
    cnt_d   = cnt_q;
    err_d   = err_q;

    // Partial remainder shifted left with the next dividend bit pulled in;
    // a set MSB of the trial difference means the subtraction underflowed.
    shifted = {a_q, q_q[W-1]};
    diff    = shifted - {1'b0, m_q};

    unique case (state_q)
      IDLE: begin
        if (start) begin
          if (Divisor != '0) begin
            m_d     = Divisor;
            q_d     = Dividend;
            a_d     = '0;
            cnt_d   = CW'(W);
            err_d   = 1'b0;
            state_d = DIV;
          end else begin
            quot_d  = '1;
            rem_d   = Dividend;
            err_d   = 1'b1;
            state_d = DONE;
          end
        end
      end
      DIV: begin
        if (diff[W]) begin
          a_d = shifted[W-1:0];
          q_d = {q_q[W-2:0], 1'b0};
        end else begin
          a_d = diff[W-1:0];
          q_d = {q_q[W-2:0], 1'b1};
        end
        cnt_d = cnt_q - CW'(1);
        // Last step: publish the results of this very step.
        if (cnt_q == CW'(1)) begin
          quot_d  = q_d;
          rem_d   = a_d;
          state_d = DONE;
        end
      end
      DONE: begin
        state_d = IDLE;
      end
      default: begin
        state_d = IDLE;
      end
    endcase
  end

  // Outputs: pure decodes of registered state
  always_comb begin
    busy      = (state_q == DIV);
    done      = (state_q == DONE);
    state     = state_q;
    counter   = cnt_q;
    Quotient  = quot_q;
    Remainder = rem_q;
    Errorout  = {1'b0, err_q};
  end

endmodule

// File: doc/restoring_divider_seq.md
Name: restoring_divider_seq

Overview:
- Sequential unsigned restoring divider, the division counterpart of the shift-add multiply sequencer.
- Takes a W-bit dividend and divisor on a start pulse and produces the quotient and remainder after W iteration cycles.
- Flags divide-by-zero on a dedicated error output.
- Sits beside the multiply controller; the top-level OP decode launches it for the divide opcode.

Parameters:
- W, 4, operand/result width in bits (W >= 2)
- CW, 3, iteration counter width; must satisfy 2^CW > W

Ports:
- clk  input  1  system clock, all state updates on rising edge
- rstn  input  1  asynchronous active-low reset
- start  input  1  request; sampled only in IDLE
- Dividend  input  W  numerator, captured on accepted start
- Divisor  input  W  denominator, captured on accepted start
- Quotient  output  W  result quotient, valid when done=1, held until next accepted start
- Remainder  output  W  result remainder, same validity as Quotient
- busy  output  1  high while in DIV state
- done  output  1  one-cycle pulse when results become valid
- Errorout  output  2  bit0 = divide-by-zero on last operation, bit1 = reserved, always 0
- state  output  2  current FSM state, for debug
- counter  output  CW  remaining iterations, for debug

Behaviour:
- Reset (asynchronous, rstn=0): state=IDLE; Quotient=0; Remainder=0; busy=0; done=0; Errorout=2'b00; counter=0; internal A/Q/M registers=0.
- Reset takes effect immediately, including mid-division; the operation is abandoned and no done pulse is produced.
- State encoding: IDLE=2'b00, DIV=2'b01, DONE=2'b10; 2'b11 is illegal and returns to IDLE on the next edge.
- IDLE with start=1 and Divisor!=0: M<=Divisor, Q<=Dividend, A<=0, counter<=W, Errorout<=0; go to DIV.
- IDLE with start=1 and Divisor==0: go to DONE directly with Quotient<=all ones, Remainder<=Dividend, Errorout<=2'b01.
- IDLE with start=0: hold all state.
- DIV, each cycle performs one restoring step:
  - shifted = {A, Q[W-1]} (W+1 bits); diff = shifted - {1'b0, M} in W+1 bits.
  - If diff[W]=1 (negative): A<=shifted[W-1:0] (restore) and Q<={Q[W-2:0],1'b0}.
  - Otherwise: A<=diff[W-1:0] and Q<={Q[W-2:0],1'b1}.
  - counter decrements by 1.
  - When counter==1 at the edge, the step completes, Quotient<=next Q, Remainder<=next A, and the FSM goes to DONE.
- DONE: done=1 for exactly one cycle, then IDLE. Quotient, Remainder and Errorout stay held until the next accepted start.
- busy=1 exactly in DIV; done=1 exactly in DONE; both are registered state decodes, with no combinational path from start.
- Latency: start accepted at edge N gives DIV during cycles N+1..N+W and done=1 in cycle N+W+1. For divide-by-zero, done=1 in cycle N+1.
- start during DIV or DONE is ignored, not queued. Operand changes after acceptance have no effect.
- start held high continuously: a new operation begins on the first IDLE cycle after DONE, so back-to-back throughput is one result per W+2 cycles.
- Arithmetic: unsigned throughout. Invariant on completion: Dividend = Quotient*Divisor + Remainder, with Remainder < Divisor.

Test Plan:
- W=4, Dividend=13, Divisor=3, start pulse at edge 0 -> busy cycles 1–4, done in cycle 5, Quotient=4, Remainder=1, Errorout=00.
- Dividend=7, Divisor=0 -> done in the next cycle, busy never high, Quotient=4'hF, Remainder=7, Errorout=01; a following 6/2 run returns Quotient=3, Remainder=0, Errorout=00.
- Boundaries: 15/1 -> Q=15, R=0; 3/5 -> Q=0, R=3; 15/15 -> Q=1, R=0; 0/7 -> Q=0, R=0.
- Start 9/2, then pulse start with 15/1 during cycle 2 of DIV -> second request ignored; result Q=4, R=1; exactly one done pulse.
- Start 14/3, drive rstn=0 during cycle 2 of DIV -> all outputs 0 asynchronously and state=IDLE; after release, 14/3 -> Q=4, R=2.
- Exhaustive W=4 sweep of all 256 operand pairs with start held high -> every result matches the invariant (divisor 0 gives the error row), with done spacing of 6 cycles.
